decode_pipe: RTL and testbench
==============================

DECODE_PIPE -- requirements
Module: decode_pipe

Interface
REQ-001 SHALL have parameter DATA_W, default 16, meaning register/datapath width (>=16).
REQ-002 SHALL have parameter NREGS, default 8, meaning register count (power of two; address width AW = log2(NREGS), >=3).
REQ-003 SHALL have ports, in order:
- clk in 1: only clock, rising edge.
- rst in 1: asynchronous, active-low reset.
- in_valid in 1: upstream instruction valid.
- in_ready out 1: stage can accept.
- instr in 16: instruction word.
- pc_next in DATA_W: PC+2 of instr.
- wb_en in 1: writeback enable.
- wb_reg in AW: writeback register.
- wb_data in DATA_W: writeback data.
- flush in 1: kill held and incoming instruction.
- out_valid out 1: ID/EX register valid.
- out_ready in 1: downstream accepts.
- out_instr out 16: held instruction.
- out_pc_next out DATA_W: held PC+2.
- out_a, out_b out DATA_W: Rs (instr[10:8]) and Rt (instr[7:5]) read data.
- out_imm out DATA_W: extended immediate.
- out_wreg out AW: destination register.
- out_wen out 1: writes a register.
- out_memrd out 1: load.
- out_halt out 1: HALT.
- hazard out 1: load-use stall this cycle.

Function
REQ-004 SHALL contain NREGS x DATA_W register file, written on clk edge when wb_en; register 0 is ordinary (not hardwired).
REQ-005 SHALL register all out_* fields in one ID/EX stage: latency exactly 1 cycle from accepted input to out_valid.
REQ-006 SHALL accept input when in_valid && in_ready; SHALL drive in_ready = (!out_valid || out_ready) && !hazard.
REQ-007 SHALL hold all out_* stable while out_valid && !out_ready.
REQ-008 SHALL extend imm: opcode 010xx/101xx -> instr[4:0]; 011xx/11000/10010/001x1 -> instr[7:0]; 001x0 -> instr[10:0]; zero-extend for 01010, 01011, 10010; sign-extend otherwise; all others 0.
REQ-009 SHALL select out_wreg: R-format 11xxx except 11000/111xx-set... use instr[4:2] for opcodes 11011,11010,111xx; instr[7:5] for 010xx,101xx,10001,10011; instr[10:8] for 11000,10010; NREGS-1 for 00110,00111; out_wen=0 for 00000,00001,10000,011xx,00100,00101.
REQ-010 SHALL set out_memrd for opcode 10001, out_halt for 00000.
REQ-011 SHALL assert hazard combinationally when out_valid && out_memrd && out_wen && in_valid && out_wreg equals instr[10:8] or instr[7:5].
REQ-012 On hazard with out_ready=1, SHALL load a bubble (out_valid=0) next cycle; instruction stays upstream, accepted the following cycle.
REQ-013 On flush, SHALL clear out_valid next edge and discard the same-cycle input; flush overrides hazard and accept.
REQ-014 Simultaneous wb_en and read of same register SHALL follow REQ-022.
REQ-015 out_halt SHALL NOT stop the stage; downstream handles halt.

Reset
REQ-016 While rst=0, SHALL force out_valid=0 and all out_* fields to 0, asynchronously.
REQ-017 SHALL reset every register-file entry to 0.
REQ-018 Reset mid-transfer SHALL drop the held instruction; first post-reset edge with rst=1 behaves as empty stage.
REQ-019 hazard SHALL be 0 during reset (out_valid=0).

Configuration
REQ-020 Macro DECODE_BYPASS_EN SHALL select write-to-read bypass.
REQ-021 Without it, reads in the wb_en cycle return the old register value.
REQ-022 With it, a read of wb_reg while wb_en returns wb_data in the same cycle.

Structure
REQ-023 Shared package decode_pkg SHALL hold opcode constants, immediate-class enum (IMM_NONE/5/8/11), and the extension function.
REQ-024 The register file with optional bypass SHALL be sub-module regfile_bypass (parameters DATA_W, NREGS).

Verification
REQ-025 Reset: rst=0 mid-stream -> out_valid=0, all registers read 0 after release.
REQ-026 ADDI R1,R2,-1 (0x4220 form, imm5=11111) with R2=5 -> one cycle later out_a=5, out_imm=0xFFFF, out_wreg=1, out_wen=1.
REQ-027 LD R3,R1,0 then ADD using R3 -> hazard=1 one cycle, one bubble, ADD issued next cycle; no instruction lost or duplicated.
REQ-028 out_ready=0 for 3 cycles with valid output -> out_* unchanged, in_ready=0, then resumes in order.
REQ-029 wb_en R4=0x1234 while decoding read of R4 -> out_a=0x1234 with DECODE_BYPASS_EN, old value without.
REQ-030 flush with in_valid=1 and out_valid=1 -> out_valid=0 next cycle, flushed input not issued.

Source files
------------

// File: rtl/decode_pkg.sv
// decode_pkg: shared decode definitions for the decode_pipe block.
//   - opcode constants (opcode = instr[15:11])
//   - immediate-class enum and the immediate extension function
//   - destination-register selector enum and its decode function
package decode_pkg;

    localparam int unsigned OPC_W   = 5;
    localparam int unsigned INSTR_W = 16;

    localparam logic [OPC_W-1:0] OP_HALT      = 5'b00000;
    localparam logic [OPC_W-1:0] OP_LINK_A    = 5'b00110;
    localparam logic [OPC_W-1:0] OP_LINK_B    = 5'b00111;
    localparam logic [OPC_W-1:0] OP_ZIMM5_A   = 5'b01010;
    localparam logic [OPC_W-1:0] OP_ZIMM5_B   = 5'b01011;
    localparam logic [OPC_W-1:0] OP_LOAD      = 5'b10001;
    localparam logic [OPC_W-1:0] OP_ZIMM8     = 5'b10010;
    localparam logic [OPC_W-1:0] OP_RT_DST    = 5'b10011;
    localparam logic [OPC_W-1:0] OP_MOV_IMM8  = 5'b11000;
    localparam logic [OPC_W-1:0] OP_RR_A      = 5'b11010;
    localparam logic [OPC_W-1:0] OP_RR_B      = 5'b11011;

    typedef enum logic [1:0] {
        IMM_NONE,
        IMM_5,
        IMM_8,
        IMM_11
    } imm_class_e;

    typedef enum logic [2:0] {
        DST_NONE,   // no register written
        DST_RD,     // instr[4:2]
        DST_RT,     // instr[7:5]
        DST_RS,     // instr[10:8]
        DST_LINK    // highest register
    } dst_sel_e;

    function automatic imm_class_e imm_class(input logic [OPC_W-1:0] op);
        imm_class_e c;
        c = IMM_NONE;
        casez (op)
            5'b010??, 5'b101??:                          c = IMM_5;
            5'b011??, OP_MOV_IMM8, OP_ZIMM8, 5'b001?1:   c = IMM_8;
            5'b001?0:                                    c = IMM_11;
            default:                                     c = IMM_NONE;
        endcase
        return c;
    endfunction

    function automatic logic imm_zero_ext(input logic [OPC_W-1:0] op);
        return (op == OP_ZIMM5_A) || (op == OP_ZIMM5_B) || (op == OP_ZIMM8);
    endfunction

    // Result is 16 bits wide; every immediate is at most 11 bits, so a
    // zero-extended value always has bit 15 clear and the caller may
    // sign-extend this result to any wider datapath.
    function automatic logic [INSTR_W-1:0] ext_imm(input logic [INSTR_W-1:0] instr);
        logic [OPC_W-1:0]   op;
        logic               sx;
        logic [INSTR_W-1:0] r;
        op = instr[15:11];
        sx = !imm_zero_ext(op);
        r  = '0;
        case (imm_class(op))
            IMM_5:   r = {{11{sx & instr[4]}},  instr[4:0]};
            IMM_8:   r = {{8{sx & instr[7]}},   instr[7:0]};
            IMM_11:  r = {{5{sx & instr[10]}},  instr[10:0]};
            default: r = '0;
        endcase
        return r;
    endfunction

    function automatic dst_sel_e dst_sel(input logic [OPC_W-1:0] op);
        dst_sel_e d;
        d = DST_NONE;
        casez (op)
            OP_RR_A, OP_RR_B, 5'b111??:                  d = DST_RD;
            5'b010??, 5'b101??, OP_LOAD, OP_RT_DST:      d = DST_RT;
            OP_MOV_IMM8, OP_ZIMM8:                       d = DST_RS;
            OP_LINK_A, OP_LINK_B:                        d = DST_LINK;
            default:                                     d = DST_NONE;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/regfile_bypass.sv
// regfile_bypass: NREGS x DATA_W register file, one write port, two
// combinational read ports, asynchronous active-low reset clears all entries.
// Configuration macro DECODE_BYPASS_EN: when defined, a read of the register
// being written in the same cycle returns the write data; otherwise the old
// stored value is returned.
// Ports:
//   clk, rst                 clock (rising edge), async active-low reset
//   wr_en, wr_addr, wr_data  write port (takes effect on clk edge)
//   rd_addr_a / rd_data_a    read port A
//   rd_addr_b / rd_data_b    read port B
module regfile_bypass #(
    parameter  int unsigned DATA_W = 16,
    parameter  int unsigned NREGS  = 8,
    localparam int unsigned AW     = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [AW-1:0]     rd_addr_a,
    output logic [DATA_W-1:0] rd_data_a,
    input  logic [AW-1:0]     rd_addr_b,
    output logic [DATA_W-1:0] rd_data_b
);

    logic [DATA_W-1:0] mem [NREGS];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        rd_data_a = mem[rd_addr_a];
        rd_data_b = mem[rd_addr_b];
`ifdef DECODE_BYPASS_EN
        if (wr_en && (wr_addr == rd_addr_a)) rd_data_a = wr_data;
        if (wr_en && (wr_addr == rd_addr_b)) rd_data_b = wr_data;
`endif
    end

endmodule

// File: rtl/decode_pipe.sv
// decode_pipe: instruction decode stage with register file and a single
// ID/EX output register. Detects load-use hazards against the held
// instruction and inserts a bubble; supports flush and downstream stall.
// Configuration macro DECODE_BYPASS_EN (passed to regfile_bypass) selects
// write-to-read bypass of the writeback port.
// Ports:
//   clk, rst                    clock, async active-low reset
//   in_valid/in_ready, instr, pc_next    upstream instruction handshake
//   wb_en, wb_reg, wb_data      register writeback
//   flush                       kill held and incoming instruction
//   out_valid/out_ready         downstream handshake
//   out_instr, out_pc_next, out_a, out_b, out_imm, out_wreg, out_wen,
//   out_memrd, out_halt         registered decode results
//   hazard                      combinational load-use stall indicator
module decode_pipe
    import decode_pkg::*;
#(
    parameter  int unsigned DATA_W = 16,
    parameter  int unsigned NREGS  = 8,
    localparam int unsigned AW     = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [15:0]       instr,
    input  logic [DATA_W-1:0] pc_next,
    input  logic              wb_en,
    input  logic [AW-1:0]     wb_reg,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [15:0]       out_instr,
    output logic [DATA_W-1:0] out_pc_next,
    output logic [DATA_W-1:0] out_a,
    output logic [DATA_W-1:0] out_b,
    output logic [DATA_W-1:0] out_imm,
    output logic [AW-1:0]     out_wreg,
    output logic              out_wen,
    output logic              out_memrd,
    output logic              out_halt,
    output logic              hazard
);

    logic [OPC_W-1:0]  opcode;
    logic [AW-1:0]     rs_addr;
    logic [AW-1:0]     rt_addr;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic [15:0]       imm16;
    logic [DATA_W-1:0] d_imm;
    logic [AW-1:0]     d_wreg;
    logic              d_wen;
    logic              accept;

    assign opcode  = instr[15:11];
    assign rs_addr = AW'(instr[10:8]);
    assign rt_addr = AW'(instr[7:5]);

    regfile_bypass #(
        .DATA_W (DATA_W),
        .NREGS  (NREGS)
    ) u_regfile (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wb_en),
        .wr_addr   (wb_reg),
        .wr_data   (wb_data),
        .rd_addr_a (rs_addr),
        .rd_data_a (rs_data),
        .rd_addr_b (rt_addr),
        .rd_data_b (rt_data)
    );

    // The 16-bit immediate is already correctly extended to 16 bits, so a
    // signed widening gives the right value for any DATA_W >= 16.
    assign imm16 = ext_imm(instr);
    assign d_imm = DATA_W'($signed(imm16));

    always_comb begin
        d_wreg = '0;
        d_wen  = 1'b1;
        case (dst_sel(opcode))
            DST_RD:   d_wreg = AW'(instr[4:2]);
            DST_RT:   d_wreg = AW'(instr[7:5]);
            DST_RS:   d_wreg = AW'(instr[10:8]);
            DST_LINK: d_wreg = AW'(NREGS - 1);
            default:  d_wen  = 1'b0;
        endcase
    end

    // Load in ID/EX whose destination is a source of the incoming instruction.
    assign hazard   = out_valid && out_memrd && out_wen && in_valid &&
                      ((out_wreg == rs_addr) || (out_wreg == rt_addr));
    assign in_ready = (!out_valid || out_ready) && !hazard;
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid   <= 1'b0;
            out_instr   <= '0;
            out_pc_next <= '0;
            out_a       <= '0;
            out_b       <= '0;
            out_imm     <= '0;
            out_wreg    <= '0;
            out_wen     <= 1'b0;
            out_memrd   <= 1'b0;
            out_halt    <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (!out_valid || out_ready) begin
            // A hazard leaves accept low, so the stage loads a bubble.
            out_valid <= accept;
            if (accept) begin
                out_instr   <= instr;
                out_pc_next <= pc_next;
                out_a       <= rs_data;
                out_b       <= rt_data;
                out_imm     <= d_imm;
                out_wreg    <= d_wreg;
                out_wen     <= d_wen;
                out_memrd   <= (opcode == OP_LOAD);
                out_halt    <= (opcode == OP_HALT);
            end
        end
    end

endmodule

// File: tb/tb_decode_pipe.sv
module tb_decode_pipe;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned NREGS  = 8;
    localparam int unsigned AW     = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [15:0]       instr;
    logic [DATA_W-1:0] pc_next;
    logic              wb_en;
    logic [AW-1:0]     wb_reg;
    logic [DATA_W-1:0] wb_data;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [15:0]       out_instr;
    logic [DATA_W-1:0] out_pc_next;
    logic [DATA_W-1:0] out_a;
    logic [DATA_W-1:0] out_b;
    logic [DATA_W-1:0] out_imm;
    logic [AW-1:0]     out_wreg;
    logic              out_wen;
    logic              out_memrd;
    logic              out_halt;
    logic              hazard;

    always #5 clk = ~clk;

    decode_pipe #(.DATA_W(DATA_W), .NREGS(NREGS)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .pc_next(pc_next), .wb_en(wb_en), .wb_reg(wb_reg),
        .wb_data(wb_data), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .out_instr(out_instr), .out_pc_next(out_pc_next),
        .out_a(out_a), .out_b(out_b), .out_imm(out_imm), .out_wreg(out_wreg),
        .out_wen(out_wen), .out_memrd(out_memrd), .out_halt(out_halt),
        .hazard(hazard)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference state: register file contents and expected ID/EX contents.
    logic [DATA_W-1:0] m_rf [NREGS];
    logic              m_valid;
    logic [15:0]       m_instr;
    logic [DATA_W-1:0] m_pc, m_a, m_b, m_imm;
    logic [AW-1:0]     m_wreg;
    logic              m_wen, m_memrd, m_halt;
    logic [DATA_W-1:0] pc_ctr;
    logic              haz_seen;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_tests++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Decode from the instruction-set rules using opcode groups and plain
    // arithmetic on the immediate field.
    function automatic void ref_decode(input logic [15:0] ins, output logic [15:0] imm,
                                       output logic [2:0] wreg, output logic wen,
                                       output logic memrd, output logic halt);
        logic [4:0] op;
        logic [2:0] grp;
        int width, raw;
        bit zext;
        op    = ins[15:11];
        grp   = op[4:2];
        width = 0;
        if (grp == 3'b010 || grp == 3'b101) width = 5;
        else if (grp == 3'b011 || op == 5'b11000 || op == 5'b10010 ||
                 (grp == 3'b001 && op[0])) width = 8;
        else if (grp == 3'b001) width = 11;
        zext = (op == 5'b01010 || op == 5'b01011 || op == 5'b10010);
        if (width == 0) imm = 16'h0;
        else begin
            raw = int'(ins) % (1 << width);
            if (!zext && raw >= (1 << (width - 1))) raw = raw - (1 << width);
            imm = raw[15:0];
        end
        wen = 1'b1;
        if (op == 5'b11011 || op == 5'b11010 || grp == 3'b111) wreg = ins[4:2];
        else if (grp == 3'b010 || grp == 3'b101 || op == 5'b10001 || op == 5'b10011) wreg = ins[7:5];
        else if (op == 5'b11000 || op == 5'b10010) wreg = ins[10:8];
        else if (op == 5'b00110 || op == 5'b00111) wreg = 3'(NREGS - 1);
        else begin wreg = 3'd0; wen = 1'b0; end
        memrd = (op == 5'b10001);
        halt  = (op == 5'b00000);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NREGS; i++) m_rf[i] = '0;
        m_valid = 0; m_instr = '0; m_pc = '0; m_a = '0; m_b = '0; m_imm = '0;
        m_wreg = '0; m_wen = 0; m_memrd = 0; m_halt = 0;
    endtask

    task automatic check_outputs();
        chk("out_valid", out_valid, m_valid);
        if (m_valid) begin
            chk("out_instr", out_instr, m_instr);
            chk("out_pc_next", out_pc_next, m_pc);
            chk("out_a", out_a, m_a);
            chk("out_b", out_b, m_b);
            chk("out_imm", out_imm, m_imm);
            chk("out_wreg", out_wreg, m_wreg);
            chk("out_wen", out_wen, m_wen);
            chk("out_memrd", out_memrd, m_memrd);
            chk("out_halt", out_halt, m_halt);
        end
    endtask

    // Asynchronous reset asserted away from any clock edge; outputs must
    // clear immediately.
    task automatic apply_reset();
        in_valid = 0; wb_en = 0; flush = 0; out_ready = 1; instr = '0;
        rst = 0;
        #1;
        model_reset();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_hazard", hazard, 0);
        chk("rst_fields", {out_instr, out_pc_next, out_a, out_b}, 64'h0);
        chk("rst_fields2", {out_imm, out_wreg, out_wen, out_memrd, out_halt}, 64'h0);
        repeat (2) @(negedge clk);
        rst = 1;
    endtask

    // One clock cycle: drive after the falling edge, check combinational
    // outputs, advance the model, check registered outputs after the edge.
    task automatic step(input logic iv, input logic [15:0] ins, input logic ordy,
                        input logic we, input logic [2:0] wr, input logic [15:0] wd,
                        input logic fl);
        logic eh, er, acc;
        logic [15:0] ra, rb, imm;
        logic [2:0] wreg;
        logic wen, mrd, hlt;
        in_valid = iv; instr = ins; pc_next = pc_ctr; out_ready = ordy;
        wb_en = we; wb_reg = wr; wb_data = wd; flush = fl;
        #1;
        eh = m_valid && m_memrd && m_wen && iv && (m_wreg == ins[10:8] || m_wreg == ins[7:5]);
        er = (!m_valid || ordy) && !eh;
        haz_seen = hazard;
        chk("hazard", hazard, eh);
        chk("in_ready", in_ready, er);
        acc = iv && er;
        ra = m_rf[ins[10:8]];
        rb = m_rf[ins[7:5]];
`ifdef DECODE_BYPASS_EN
        if (we && wr == ins[10:8]) ra = wd;
        if (we && wr == ins[7:5])  rb = wd;
`endif
        if (fl) m_valid = 0;
        else if (!m_valid || ordy) begin
            if (acc) begin
                ref_decode(ins, imm, wreg, wen, mrd, hlt);
                m_valid = 1; m_instr = ins; m_pc = pc_ctr; m_a = ra; m_b = rb;
                m_imm = imm; m_wreg = wreg; m_wen = wen; m_memrd = mrd; m_halt = hlt;
            end else m_valid = 0;
        end
        if (we) m_rf[wr] = wd;
        pc_ctr = pc_ctr + 16'd2;
        @(posedge clk);
        #1;
        check_outputs();
        @(negedge clk);
    endtask

    initial begin
        int unsigned r, r2;
        logic [15:0] ins;
        rst = 1; in_valid = 0; instr = '0; pc_next = '0; wb_en = 0; wb_reg = '0;
        wb_data = '0; flush = 0; out_ready = 1; pc_ctr = 16'h0100;
        model_reset();
        #2;
        apply_reset();

        // Register setup
        step(0, 16'h0, 1, 1, 3'd2, 16'h0005, 0);
        step(0, 16'h0, 1, 1, 3'd1, 16'h0100, 0);
        step(0, 16'h0, 1, 1, 3'd4, 16'h1111, 0);
        step(0, 16'h0, 1, 1, 3'd3, 16'h0033, 0);

        // ADDI R1,R2,-1
        step(1, 16'h423F, 1, 0, 3'd0, 16'h0, 0);
        chk("addi_a", out_a, 16'h0005);
        chk("addi_imm", out_imm, 16'hFFFF);
        chk("addi_wreg", out_wreg, 3'd1);
        chk("addi_wen", out_wen, 1'b1);

        // LD R3,[R1] then ADD reading R3: one bubble, ADD issued once
        step(1, 16'h8960, 1, 0, 3'd0, 16'h0, 0);
        chk("ld_memrd", out_memrd, 1'b1);
        step(1, 16'hDB44, 1, 0, 3'd0, 16'h0, 0);
        chk("ld_use_hazard", haz_seen, 1'b1);
        chk("ld_use_bubble", out_valid, 1'b0);
        step(1, 16'hDB44, 1, 0, 3'd0, 16'h0, 0);
        chk("add_issued", out_instr, 16'hDB44);
        chk("add_valid", out_valid, 1'b1);
        step(0, 16'h0, 1, 0, 3'd0, 16'h0, 0);
        chk("add_not_dup", out_valid, 1'b0);

        // Downstream stall for three cycles
        step(1, 16'h4A25, 1, 0, 3'd0, 16'h0, 0);
        for (int k = 0; k < 3; k++) begin
            step(1, 16'h5123, 0, 0, 3'd0, 16'h0, 0);
            chk("stall_hold", out_instr, 16'h4A25);
        end
        step(1, 16'h5123, 1, 0, 3'd0, 16'h0, 0);
        chk("stall_resume", out_instr, 16'h5123);

        // Writeback of R4 while decoding a read of R4
        step(1, 16'hDC00, 1, 1, 3'd4, 16'h1234, 0);
`ifdef DECODE_BYPASS_EN
        chk("wb_read_a", out_a, 16'h1234);
`else
        chk("wb_read_a", out_a, 16'h1111);
`endif

        // Flush with a held and an incoming instruction
        step(1, 16'h4A25, 1, 0, 3'd0, 16'h0, 0);
        step(1, 16'h5123, 1, 0, 3'd0, 16'h0, 1);
        chk("flush_valid", out_valid, 1'b0);
        step(0, 16'h0, 1, 0, 3'd0, 16'h0, 0);
        chk("flush_not_issued", out_valid, 1'b0);

        // Reset while an instruction is held, then read back every register
        step(1, 16'h8960, 0, 0, 3'd0, 16'h0, 0);
        #2;
        apply_reset();
        for (int i = 0; i < NREGS; i++) begin
            ins = {5'b11011, 3'(i), 3'(i), 5'b0};
            step(1, ins, 1, 0, 3'd0, 16'h0, 0);
            chk("post_rst_reg", {out_a, out_b}, 32'h0);
        end

        // Randomized traffic, biased toward loads to provoke hazards
        for (int n = 0; n < 400; n++) begin
            r  = $urandom();
            r2 = $urandom();
            ins = r[15:0];
            if (r2[1:0] == 2'b00) ins[15:11] = 5'b10001;
            step(r2[4:2] != 3'b000, ins, r2[7:5] != 3'b000, r2[8],
                 r2[11:9], r2[27:12], r2[31:28] == 4'h0);
        end
        step(0, 16'h0, 1, 0, 3'd0, 16'h0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
